// File: rtl/sipo_collector.sv
// Serial-to-parallel word collector with sof alignment and a one-entry valid/ready
// holding register; reports dropped words (overrun) and broken frames (frame_err).
module sipo_collector #(
    parameter int unsigned  WIDTH     = 4,
    parameter bit           MSB_FIRST = 1'b0,
    localparam int unsigned CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    input  logic             par_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic [CW-1:0]    bit_cnt
);

    localparam int unsigned IW = $clog2(WIDTH);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;

    logic             start;
    logic             accept;
    logic             done;
    logic [CW-1:0]    cnt_eff;
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] word;
    logic [IW-1:0]    pos;

    // A sof restarts the word at bit 0 regardless of how much was collected.
    always_comb begin
        start   = ser_valid & sof;
        accept  = ser_valid & (sof | (state_q == StShift));
        cnt_eff = start ? '0 : bit_cnt;
        base    = start ? '0 : shreg_q;
        if (MSB_FIRST) begin
            pos = IW'(WIDTH - 1 - 32'(cnt_eff));
        end else begin
            pos = IW'(cnt_eff);
        end
        word      = base;
        word[pos] = ser_in;
        done      = accept && (32'(cnt_eff) == WIDTH - 1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bit_cnt   <= '0;
            par_out   <= '0;
            par_valid <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;

            if (accept) begin
                state_q <= StShift;
                if (start && (bit_cnt != '0)) begin
                    frame_err <= 1'b1;
                end
                if (done) begin
                    bit_cnt <= '0;
                    shreg_q <= '0;
                end else begin
                    bit_cnt <= cnt_eff + CW'(1);
                    shreg_q <= word;
                end
            end

            // Holding register: load when free or draining, otherwise drop the word.
            if (done && (!par_valid || par_ready)) begin
                par_out   <= word;
                par_valid <= 1'b1;
            end else begin
                if (done) begin
                    overrun <= 1'b1;
                end
                if (par_valid && par_ready) begin
                    par_valid <= 1'b0;
                end
            end
        end
    end

endmodule
